// File: rtl/bombjack_rom_loader_pkg.sv
// Shared definitions for the Bomb Jack ROM loader: address map, the
// SDRAM write entry carried through each port FIFO, and port FSM states.
package bombjack_loader_pkg;

  localparam logic [24:0] CPU_BASE = 25'h000_0000;
  localparam logic [24:0] GFX_BASE = 25'h000_C000;
  localparam logic [24:0] ROM_END  = 25'h001_8000;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } port_state_t;

endpackage

// File: rtl/bombjack_rom_loader_port.sv
// One SDRAM write port: a 2-entry FIFO of write entries drained by a
// toggle-handshake FSM (one outstanding request at a time).
module loader_port
  import bombjack_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [40:0] push_data,
  input  logic        ack,
  output logic        req,
  output logic [22:0] a,
  output logic [1:0]  ds,
  output logic [15:0] d,
  output logic        overflow,
  output logic        idle
);

  port_state_t state_q, state_d;
  wr_entry_t   mem_q [2];
  wr_entry_t   mem_d [2];
  wr_entry_t   head;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        req_q, req_d;
  logic [22:0] a_q, a_d;
  logic [1:0]  ds_q, ds_d;
  logic [15:0] d_q, d_d;
  logic        pop, full, wr_en;

  // A full FIFO still accepts a push when the head retires in the same cycle.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    pop      = (state_q == ST_WAIT) && (ack == req_q);
    full     = (count_q == 2'd2);
    wr_en    = push && (!full || pop);
    overflow = push && full && !pop;
    idle     = (state_q == ST_IDLE) && (count_q == 2'd0);
    mem_d    = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = wr_entry_t'(push_data);
    wr_ptr_d = wr_en ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, wr_en} - {1'b0, pop};
  end

  // Next state: issue when something is queued, retire when ack matches req.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (count_q != 2'd0) state_d = ST_WAIT;
      ST_WAIT: if (pop)             state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Port outputs load only when a request is issued, so they hold through WAIT.
  always_comb begin
    req_d = req_q;
    a_d   = a_q;
    ds_d  = ds_q;
    d_d   = d_q;
    if (state_q == ST_IDLE && count_q != 2'd0) begin
      req_d = ~req_q;
      a_d   = head.a;
      ds_d  = head.ds;
      d_d   = head.d;
    end
  end

  // State register; a reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FIFO control and port output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      req_q    <= 1'b0;
      a_q      <= '0;
      ds_q     <= '0;
      d_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      req_q    <= req_d;
      a_q      <= a_d;
      ds_q     <= ds_d;
      d_q      <= d_d;
    end
  end

  // FIFO storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign req = req_q;
  assign a   = a_q;
  assign ds  = ds_q;
  assign d   = d_q;

endmodule

// File: rtl/bombjack_rom_loader.sv
// Bomb Jack ROM loader: splits the index-0 ioctl byte stream into CPU and
// graphics SDRAM write ports and reports load completion and dropped bytes.
module bombjack_rom_loader
  import bombjack_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        RESETn,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        rom_loaded,
  output logic        overflow,
  output logic [15:0] dropped
);

  logic        wr_prev_q, wr_prev_d;
  logic        downl_prev_q, downl_prev_d;
  logic        push_cpu_q, push_cpu_d;
  logic        push_gfx_q, push_gfx_d;
  logic        oor_q, oor_d;
  wr_entry_t   entry_q, entry_d;
  logic        loading_q, loading_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic        overflow_q, overflow_d;
  logic [15:0] dropped_q, dropped_d;

  logic        accept, dl_start, in_cpu, in_gfx, drop_evt;
  logic [23:0] rel_cpu;
  logic [20:0] rel_gfx;
  wr_entry_t   entry_cpu, entry_gfx;
  logic        ovf1, ovf2, idle1, idle2;

  // Byte acceptance and region decode; graphics bytes are interleaved by bit 14/13.
  always_comb begin
    accept    = ioctl_wr && !wr_prev_q && ioctl_downl && (ioctl_index == 8'd0);
    dl_start  = ioctl_downl && !downl_prev_q && (ioctl_index == 8'd0);
    in_cpu    = (ioctl_addr < GFX_BASE);
    in_gfx    = (ioctl_addr >= GFX_BASE) && (ioctl_addr < ROM_END);
    rel_cpu   = ioctl_addr[23:0] - CPU_BASE[23:0];
    rel_gfx   = ioctl_addr[20:0] - GFX_BASE[20:0];
    entry_cpu.a  = rel_cpu[23:1];
    entry_cpu.ds = {rel_cpu[0], ~rel_cpu[0]};
    entry_cpu.d  = {ioctl_dout, ioctl_dout};
    entry_gfx.a  = {3'b000, rel_gfx[20:15], rel_gfx[12:0], rel_gfx[14]};
    entry_gfx.ds = {rel_gfx[13], ~rel_gfx[13]};
    entry_gfx.d  = {ioctl_dout, ioctl_dout};
  end

  // Status tracking: clear on index-0 download start, flag load done once drained.
  always_comb begin
    wr_prev_d    = ioctl_wr;
    downl_prev_d = ioctl_downl;
    push_cpu_d   = accept && in_cpu;
    push_gfx_d   = accept && in_gfx;
    oor_d        = accept && !in_cpu && !in_gfx;
    entry_d      = in_cpu ? entry_cpu : entry_gfx;
    drop_evt     = oor_q || ovf1 || ovf2;
    overflow_d   = overflow_q || ovf1 || ovf2;
    dropped_d    = dropped_q;
    if (drop_evt && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
    loading_d    = loading_q;
    rom_loaded_d = rom_loaded_q;
    if (loading_q && !ioctl_downl && idle1 && idle2 && !push_cpu_q && !push_gfx_q) begin
      rom_loaded_d = 1'b1;
      loading_d    = 1'b0;
    end
    if (dl_start) begin
      rom_loaded_d = 1'b0;
      overflow_d   = 1'b0;
      dropped_d    = 16'd0;
      loading_d    = 1'b1;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk_sys) begin
    if (!RESETn) begin
      wr_prev_q    <= 1'b0;
      downl_prev_q <= 1'b0;
      push_cpu_q   <= 1'b0;
      push_gfx_q   <= 1'b0;
      oor_q        <= 1'b0;
      loading_q    <= 1'b0;
      rom_loaded_q <= 1'b0;
      overflow_q   <= 1'b0;
      dropped_q    <= 16'd0;
    end else begin
      wr_prev_q    <= wr_prev_d;
      downl_prev_q <= downl_prev_d;
      push_cpu_q   <= push_cpu_d;
      push_gfx_q   <= push_gfx_d;
      oor_q        <= oor_d;
      loading_q    <= loading_d;
      rom_loaded_q <= rom_loaded_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
    end
  end

  // Decoded entry waiting one cycle for its FIFO push; qualified by push_*_q.
  always_ff @(posedge clk_sys) begin
    entry_q <= entry_d;
  end

  loader_port u_port1 (
    .clk       (clk_sys),
    .rst_n     (RESETn),
    .push      (push_cpu_q),
    .push_data (entry_q),
    .ack       (port1_ack),
    .req       (port1_req),
    .a         (port1_a),
    .ds        (port1_ds),
    .d         (port1_d),
    .overflow  (ovf1),
    .idle      (idle1)
  );

  loader_port u_port2 (
    .clk       (clk_sys),
    .rst_n     (RESETn),
    .push      (push_gfx_q),
    .push_data (entry_q),
    .ack       (port2_ack),
    .req       (port2_req),
    .a         (port2_a),
    .ds        (port2_ds),
    .d         (port2_d),
    .overflow  (ovf2),
    .idle      (idle2)
  );

  assign rom_loaded = rom_loaded_q;
  assign overflow   = overflow_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_bombjack_rom_loader.sv
// Bench for bombjack_rom_loader: table-driven directed bytes, an SDRAM ack
// responder that scoreboards every request, and multi-cycle corner sequences.
module tb_bombjack_rom_loader;

  logic        clk_sys = 1'b0;
  logic        RESETn;
  logic        ioctl_downl;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_ack;
  logic [22:0] port1_a;
  logic [1:0]  port1_ds;
  logic [15:0] port1_d;
  logic        port2_req, port2_ack;
  logic [22:0] port2_a;
  logic [1:0]  port2_ds;
  logic [15:0] port2_d;
  logic        rom_loaded, overflow;
  logic [15:0] dropped;

  always #10 clk_sys = ~clk_sys;

  bombjack_rom_loader dut (
    .clk_sys(clk_sys), .RESETn(RESETn),
    .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .rom_loaded(rom_loaded), .overflow(overflow), .dropped(dropped)
  );

  typedef struct {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } exp_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  dat;
    int          port;   // 1 = CPU, 2 = GFX, 0 = dropped
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q_p1[$];
  exp_t q_p2[$];
  bit   hold [2];
  int   dly  [2];
  int   cnt  [2];
  bit   pend [2];
  logic last_req [2];
  int   toggles [2];

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  // Expected SDRAM write for a byte, straight from the address map.
  function automatic int model(input logic [24:0] addr, input logic [7:0] dat, output exp_t e);
    logic [24:0] r;
    e.d = {dat, dat};
    e.a = '0;
    e.ds = '0;
    if (addr < 25'h000C000) begin
      e.a  = addr[23:1];
      e.ds = addr[0] ? 2'b10 : 2'b01;
      return 1;
    end else if (addr < 25'h0018000) begin
      r    = addr - 25'h000C000;
      e.a  = {3'b000, r[20:15], r[12:0], r[14]};
      e.ds = r[13] ? 2'b10 : 2'b01;
      return 2;
    end
    return 0;
  endfunction

  // SDRAM side: score each req toggle against the queue, ack after dly cycles.
  task automatic serve(input int p);
    logic r;
    exp_t got, exp;
    r      = (p == 0) ? port1_req : port2_req;
    got.a  = (p == 0) ? port1_a   : port2_a;
    got.ds = (p == 0) ? port1_ds  : port2_ds;
    got.d  = (p == 0) ? port1_d   : port2_d;
    if (r !== last_req[p]) begin
      toggles[p]++;
      last_req[p] = r;
      if ((p == 0 && q_p1.size() == 0) || (p == 1 && q_p2.size() == 0)) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req port%0d: got a=0x%0h, expected no request", p + 1, got.a);
      end else begin
        if (p == 0) exp = q_p1.pop_front();
        else        exp = q_p2.pop_front();
        check($sformatf("port%0d_a", p + 1), 32'(got.a), 32'(exp.a));
        check($sformatf("port%0d_ds", p + 1), 32'(got.ds), 32'(exp.ds));
        check($sformatf("port%0d_d", p + 1), 32'(got.d), 32'(exp.d));
      end
      pend[p] = 1'b1;
      cnt[p]  = dly[p];
    end
    if (pend[p] && !hold[p]) begin
      if (cnt[p] == 0) begin
        if (p == 0) port1_ack = r;
        else        port2_ack = r;
        pend[p] = 1'b0;
      end else begin
        cnt[p]--;
      end
    end
  endtask

  always @(negedge clk_sys) begin
    if (RESETn) begin
      serve(0);
      serve(1);
    end
  end

  task automatic clear_model();
    port1_ack = 1'b0;
    port2_ack = 1'b0;
    for (int p = 0; p < 2; p++) begin
      last_req[p] = 1'b0;
      pend[p]     = 1'b0;
      cnt[p]      = 0;
      toggles[p]  = 0;
    end
    q_p1.delete();
    q_p2.delete();
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] dat, input int gap);
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_dout = dat;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk_sys);
  endtask

  // Queue the model's expectation for a byte, then send it.
  task automatic expect_send(input logic [24:0] addr, input logic [7:0] dat, input int gap);
    exp_t e;
    int   p;
    p = model(addr, dat, e);
    if (p == 1) q_p1.push_back(e);
    if (p == 2) q_p2.push_back(e);
    send_byte(addr, dat, gap);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q_p1.size() != 0 || q_p2.size() != 0 || pend[0] || pend[1]) && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d/%0d entries outstanding, expected 0", name, q_p1.size(), q_p2.size());
    end
    repeat (3) @(negedge clk_sys);
  endtask

  vec_t tbl [10];

  initial begin
    int t0, t1, e1, e2, edrop;
    logic [24:0] starts [3];

    tbl[0] = '{25'h0000003, 8'hA5, 1, 23'h000001, 2'b10, 16'hA5A5};
    tbl[1] = '{25'h0000000, 8'h3C, 1, 23'h000000, 2'b01, 16'h3C3C};
    tbl[2] = '{25'h000BFFF, 8'hFF, 1, 23'h005FFF, 2'b10, 16'hFFFF};
    tbl[3] = '{25'h0012001, 8'h5A, 2, 23'h000003, 2'b10, 16'h5A5A};
    tbl[4] = '{25'h000C000, 8'h11, 2, 23'h000000, 2'b01, 16'h1111};
    tbl[5] = '{25'h0017FFF, 8'h77, 2, 23'h007FFE, 2'b10, 16'h7777};
    tbl[6] = '{25'h000E000, 8'h22, 2, 23'h000000, 2'b10, 16'h2222};
    tbl[7] = '{25'h0010000, 8'h33, 2, 23'h000001, 2'b01, 16'h3333};
    tbl[8] = '{25'h0018000, 8'h99, 0, 23'h0, 2'b00, 16'h0};
    tbl[9] = '{25'h1FFFFFF, 8'h44, 0, 23'h0, 2'b00, 16'h0};

    RESETn = 1'b0;
    ioctl_downl = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    hold = '{1'b0, 1'b0};
    dly  = '{4, 4};
    clear_model();
    repeat (3) @(negedge clk_sys);
    check("reset_port1_req", 32'(port1_req), 0);
    check("reset_port2_req", 32'(port2_req), 0);
    check("reset_port1_a", 32'(port1_a), 0);
    check("reset_port2_d", 32'(port2_d), 0);
    check("reset_rom_loaded", 32'(rom_loaded), 0);
    check("reset_overflow", 32'(overflow), 0);
    check("reset_dropped", 32'(dropped), 0);
    RESETn = 1'b1;
    @(negedge clk_sys);

    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Directed vectors, one at a time with acks 4 cycles after each request.
    e1 = 0; e2 = 0; edrop = 0;
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.a = tbl[i].a; e.ds = tbl[i].ds; e.d = tbl[i].d;
      if (tbl[i].port == 1) begin q_p1.push_back(e); e1++; end
      else if (tbl[i].port == 2) begin q_p2.push_back(e); e2++; end
      else edrop++;
      send_byte(tbl[i].addr, tbl[i].dat, 14);
      check($sformatf("vec%0d_port1_toggles", i), 32'(toggles[0]), 32'(e1));
      check($sformatf("vec%0d_port2_toggles", i), 32'(toggles[1]), 32'(e2));
      check($sformatf("vec%0d_dropped", i), 32'(dropped), 32'(edrop));
    end
    wait_drain("table");
    check("table_overflow", 32'(overflow), 0);
    check("table_rom_loaded", 32'(rom_loaded), 0);

    // Non-zero index bytes are ignored; a long wr pulse is one byte.
    t0 = toggles[0];
    ioctl_index = 8'd1;
    send_byte(25'h0000010, 8'h01, 10);
    ioctl_index = 8'd0;
    check("index1_ignored", 32'(toggles[0]), 32'(t0));
    check("index1_not_counted", 32'(dropped), 2);
    begin
      exp_t e;
      void'(model(25'h0000011, 8'hC3, e));
      q_p1.push_back(e);
    end
    @(negedge clk_sys);
    ioctl_addr = 25'h0000011; ioctl_dout = 8'hC3; ioctl_wr = 1'b1;
    repeat (6) @(negedge clk_sys);
    ioctl_wr = 1'b0;
    wait_drain("long_wr");
    check("long_wr_one_toggle", 32'(toggles[0]), 32'(t0 + 1));

    // Back-pressure: ack withheld, third byte finds the FIFO full.
    t0 = toggles[0];
    hold[0] = 1'b1;
    expect_send(25'h0000100, 8'h10, 1);
    expect_send(25'h0000101, 8'h11, 1);
    send_byte(25'h0000102, 8'h12, 4);
    check("bp_overflow", 32'(overflow), 1);
    check("bp_dropped", 32'(dropped), 3);
    check("bp_one_in_flight", 32'(toggles[0]), 32'(t0 + 1));
    hold[0] = 1'b0;
    wait_drain("bp");
    check("bp_two_toggles", 32'(toggles[0]), 32'(t0 + 2));

    // Download end then restart clears status.
    ioctl_downl = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("first_load_done", 32'(rom_loaded), 1);
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("restart_rom_loaded", 32'(rom_loaded), 0);
    check("restart_overflow", 32'(overflow), 0);
    check("restart_dropped", 32'(dropped), 0);

    // End of load: dense bytes across the map with immediate acks.
    dly = '{0, 0};
    t0 = toggles[0];
    t1 = toggles[1];
    starts[0] = 25'h0000000;
    starts[1] = 25'h000BF00;
    starts[2] = 25'h0017E00;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 512; k++) begin
        logic [24:0] ad;
        ad = starts[s] + 25'(k);
        expect_send(ad, ad[7:0] ^ 8'h5A, 1);
      end
    end
    wait_drain("bulk");
    check("bulk_port1_toggles", 32'(toggles[0] - t0), 768);
    check("bulk_port2_toggles", 32'(toggles[1] - t1), 768);
    check("bulk_not_loaded_yet", 32'(rom_loaded), 0);
    hold[1] = 1'b1;
    expect_send(25'h000C001, 8'hE7, 2);
    ioctl_downl = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("loaded_waits_for_ack", 32'(rom_loaded), 0);
    hold[1] = 1'b0;
    wait_drain("last_ack");
    check("load_done", 32'(rom_loaded), 1);
    check("load_dropped", 32'(dropped), 0);
    check("load_overflow", 32'(overflow), 0);

    // Out-of-range byte is counted but never requested.
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
    t0 = toggles[0];
    t1 = toggles[1];
    send_byte(25'h0018000, 8'h66, 10);
    check("oor_port1_quiet", 32'(toggles[0]), 32'(t0));
    check("oor_port2_quiet", 32'(toggles[1]), 32'(t1));
    check("oor_dropped", 32'(dropped), 1);

    // Reset while a request is outstanding.
    hold[0] = 1'b1;
    t0 = toggles[0];
    expect_send(25'h0000040, 8'h81, 1);
    expect_send(25'h0000041, 8'h82, 4);
    check("mid_wait_issued", 32'(toggles[0]), 32'(t0 + 1));
    @(negedge clk_sys);
    RESETn = 1'b0;
    hold = '{1'b0, 1'b0};
    clear_model();
    @(negedge clk_sys);
    RESETn = 1'b1;
    check("rst_wait_port1_req", 32'(port1_req), 0);
    check("rst_wait_port1_a", 32'(port1_a), 0);
    check("rst_wait_port1_ds", 32'(port1_ds), 0);
    check("rst_wait_rom_loaded", 32'(rom_loaded), 0);
    check("rst_wait_dropped", 32'(dropped), 0);
    repeat (6) @(negedge clk_sys);
    check("rst_wait_no_stale_req", 32'(toggles[0]), 0);
    expect_send(25'h0000020, 8'h5C, 4);
    wait_drain("post_reset");
    check("post_reset_one_toggle", 32'(toggles[0]), 1);
    check("post_reset_req_high", 32'(port1_req), 1);

    ioctl_downl = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("final_loaded", 32'(rom_loaded), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
